// File: rtl/struct_s.sv
// Shared packet definitions for the flow-control link: ACK packet layout and
// protocol constants used by both the scheduler and the peer link parser.
package struct_s;

  localparam logic [15:0] PROT_ETH     = 16'h0800;
  localparam logic [3:0]  IP_V4        = 4'd4;
  localparam logic [7:0]  PROT_UDP     = 8'd17;
  localparam logic [15:0] ACK_PKT_PORT = 16'hF1C0;
  // 14 B eth + 20 B ip + 8 B udp + 4 B payload = 46 B of a 64 B flit
  localparam logic [5:0]  ACK_EMPTY    = 6'd18;

  typedef struct packed {
    logic [47:0]  eth_dst;
    logic [47:0]  eth_src;
    logic [15:0]  eth_type;
    logic [3:0]   ip_version;
    logic [3:0]   ip_ihl;
    logic [7:0]   ip_tos;
    logic [15:0]  ip_len;
    logic [15:0]  ip_id;
    logic [15:0]  ip_frag;
    logic [7:0]   ip_ttl;
    logic [7:0]   ip_proto;
    logic [15:0]  ip_csum;
    logic [31:0]  ip_src;
    logic [31:0]  ip_dst;
    logic [15:0]  udp_sport;
    logic [15:0]  udp_dport;
    logic [15:0]  udp_len;
    logic [15:0]  udp_csum;
    logic [31:0]  data;
    logic [143:0] pad;
  } ack_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ACK  = 2'd2
  } fc_state_e;

  function automatic ack_pkt_t build_ack(input logic [31:0] consumed);
    ack_pkt_t p;
    p            = '0;
    p.eth_type   = PROT_ETH;
    p.ip_version = IP_V4;
    p.ip_ihl     = 4'd5;
    p.ip_len     = 16'd32;
    p.ip_ttl     = 8'd64;
    p.ip_proto   = PROT_UDP;
    p.udp_sport  = ACK_PKT_PORT;
    p.udp_dport  = ACK_PKT_PORT;
    p.udp_len    = 16'd12;
    p.data       = consumed;
    return p;
  endfunction

endpackage

// File: rtl/flow_control_credit.sv
// Credit tracker: counts accepted data flits against the peer's consumed count
// and flags whether another flit fits in the downstream buffer.
module flow_control_credit #(
  parameter int IN_BUF_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic        ds_valid,
  input  logic [31:0] ds_consumed_flit,
  output logic        credit_ok
);

  logic [31:0] sent_cnt_q, sent_cnt_d;
  logic [31:0] ds_cnt_q, ds_cnt_d;
  logic [31:0] in_flight;

  always_comb begin
    sent_cnt_d = send ? sent_cnt_q + 32'd1 : sent_cnt_q;
    ds_cnt_d   = ds_valid ? ds_consumed_flit : ds_cnt_q;
    // modular subtraction keeps the distance correct across counter wrap
    in_flight  = sent_cnt_q - ds_cnt_q;
    credit_ok  = in_flight < 32'(IN_BUF_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt_q <= '0;
      ds_cnt_q   <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      ds_cnt_q   <= ds_cnt_d;
    end
  end

endmodule

// File: rtl/flow_control_scheduler.sv
// Merges the local data stream with periodic ACK flits onto the inter-FPGA link,
// gating data on downstream credit and never splitting a packet with an ACK.
module flow_control_scheduler
  import struct_s::*;
#(
  parameter int IN_BUF_DEPTH = 256,
  parameter int ACK_PERIOD   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] in_data,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic         in_eop,
  input  logic [5:0]   in_empty,
  output logic         in_ready,
  output logic [511:0] out_data,
  output logic         out_valid,
  output logic         out_sop,
  output logic         out_eop,
  output logic [5:0]   out_empty,
  input  logic         out_ready,
  input  logic [31:0]  ds_consumed_flit,
  input  logic         ds_valid,
  input  logic [31:0]  local_consumed_flit
);

  localparam int TW = (ACK_PERIOD > 1) ? $clog2(ACK_PERIOD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ACK_PERIOD - 1);

  fc_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ack_pending_q, ack_pending_d;
  logic [31:0]   snap_q, snap_d;

  logic credit_ok;
  logic pass_ok;
  logic data_go;
  logic ack_accept;

  flow_control_credit #(
    .IN_BUF_DEPTH(IN_BUF_DEPTH)
  ) u_credit (
    .clk             (clk),
    .rst             (rst),
    .send            (data_go),
    .ds_valid        (ds_valid),
    .ds_consumed_flit(ds_consumed_flit),
    .credit_ok       (credit_ok)
  );

  always_comb begin
    // IDLE only opens for a packet start, and only when no ACK is waiting
    pass_ok = ((state_q == ST_IDLE) && !ack_pending_q && in_sop) ||
              (state_q == ST_DATA);

    out_data  = in_data;
    out_sop   = in_sop;
    out_eop   = in_eop;
    out_empty = in_empty;
    out_valid = in_valid & credit_ok & pass_ok & ~rst;
    in_ready  = out_ready & credit_ok & pass_ok & ~rst;

    if (state_q == ST_ACK) begin
      out_data  = build_ack(snap_q);
      out_sop   = 1'b1;
      out_eop   = 1'b1;
      out_empty = ACK_EMPTY;
      out_valid = ~rst;
      in_ready  = 1'b0;
    end

    data_go    = in_valid & in_ready;
    ack_accept = (state_q == ST_ACK) & out_ready;
  end

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    timer_d       = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
    // a timeout while already pending folds into the outstanding request
    ack_pending_d = (timer_q == T_LAST) | (ack_pending_q & ~ack_accept);

    unique case (state_q)
      ST_IDLE: begin
        if (ack_pending_q) begin
          state_d = ST_ACK;
          snap_d  = local_consumed_flit;
        end else if (data_go && !in_eop) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_go && in_eop) state_d = ST_IDLE;
      end
      ST_ACK: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      ack_pending_q <= 1'b0;
      snap_q        <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ack_pending_q <= ack_pending_d;
      snap_q        <= snap_d;
    end
  end

endmodule

// File: tb/tb_flow_control_scheduler.sv
// Directed bench: data flits are queued as expectations when driven and checked
// as they leave the link; ACK flits are checked against the consumed-count value.
module tb_flow_control_scheduler;
  import struct_s::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_data;
  logic         in_valid, in_sop, in_eop;
  logic [5:0]   in_empty;
  logic         in_ready;
  logic [511:0] out_data;
  logic         out_valid, out_sop, out_eop;
  logic [5:0]   out_empty;
  logic         out_ready;
  logic [31:0]  ds_consumed_flit;
  logic         ds_valid;
  logic [31:0]  local_consumed_flit;

  typedef struct {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;

  flit_t       exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          ack_cnt = 0;
  int          n_data_acc = 0;
  logic        last_acc;
  logic        in_pkt;
  logic [31:0] exp_ack;

  flow_control_scheduler #(.IN_BUF_DEPTH(8), .ACK_PERIOD(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_ready(out_ready),
    .ds_consumed_flit(ds_consumed_flit), .ds_valid(ds_valid),
    .local_consumed_flit(local_consumed_flit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [511:0] mk_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // sample just after the falling edge, then advance one full cycle
  task automatic tick();
    ack_pkt_t a;
    flit_t    e;
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (in_ready) begin
        n_data_acc++;
        if (exp_q.size() == 0) begin
          chk("data_q_nonempty", 512'(exp_q.size()), 512'(1));
        end else begin
          e = exp_q.pop_front();
          chk("data_out", out_data, e.data);
          chk("data_sop", 512'(out_sop), 512'(e.sop));
          chk("data_eop", 512'(out_eop), 512'(e.eop));
          chk("data_empty", 512'(out_empty), 512'(e.empty));
        end
        if (out_sop) in_pkt = 1'b1;
        if (out_eop) in_pkt = 1'b0;
      end else begin
        a = out_data;
        ack_cnt++;
        chk("ack_mid_pkt", 512'(in_pkt), 512'(0));
        chk("ack_sop_eop", 512'({out_sop, out_eop}), 512'(2'b11));
        chk("ack_empty", 512'(out_empty), 512'(6'd18));
        chk("ack_eth_type", 512'(a.eth_type), 512'(16'h0800));
        chk("ack_proto", 512'(a.ip_proto), 512'(8'd17));
        chk("ack_sport", 512'(a.udp_sport), 512'(ACK_PKT_PORT));
        chk("ack_data", 512'(a.data), 512'(exp_ack));
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_accept(input int budget, output logic acc);
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      tick();
      acc = last_acc;
    end
  endtask

  task automatic push_drive(input logic sop, input logic eop);
    flit_t f;
    f.data  = mk_data();
    f.sop   = sop;
    f.eop   = eop;
    f.empty = eop ? 6'd3 : 6'd0;
    exp_q.push_back(f);
    in_data  = f.data;
    in_sop   = sop;
    in_eop   = eop;
    in_empty = f.empty;
    in_valid = 1'b1;
  endtask

  task automatic send_flit(input logic sop, input logic eop, input string tag);
    logic acc;
    push_drive(sop, eop);
    wait_accept(4, acc);
    in_valid = 1'b0;
    chk(tag, 512'(acc), 512'(1));
  endtask

  task automatic wait_ack(input int budget, input string tag);
    int base;
    base = ack_cnt;
    for (int i = 0; i < budget && ack_cnt == base; i++) tick();
    chk(tag, 512'(ack_cnt - base), 512'(1));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sop   = 1'b1;
    #1;
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    in_pkt   = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    logic         acc;
    logic [511:0] held;
    int           base;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_empty = '0; out_ready = 1'b1; ds_consumed_flit = '0; ds_valid = 1'b0;
    in_pkt = 1'b0; local_consumed_flit = 32'h0000_00C3; exp_ack = 32'h0000_00C3;
    @(negedge clk);

    // credit stop at 8 in flight, resumed by a consumed-count update
    do_reset();
    chk("rst_state", 512'(dut.state_q), 512'(ST_IDLE));
    in_data = mk_data(); in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
    tick();
    chk("idle_nosop_ready", 512'(in_ready), 512'(0));
    chk("idle_nosop_valid", 512'(out_valid), 512'(0));
    in_valid = 1'b0;
    base = n_data_acc;
    for (int i = 0; i < 8; i++) send_flit(i == 0, 1'b0, "credit_pass");
    chk("credit_pass_count", 512'(n_data_acc - base), 512'(8));
    push_drive(1'b0, 1'b0);
    wait_accept(6, acc);
    chk("credit_stop_acc", 512'(acc), 512'(0));
    chk("credit_stop_ready", 512'(in_ready), 512'(0));
    chk("credit_stop_inflight", 512'(dut.u_credit.in_flight), 512'(8));
    ds_consumed_flit = 32'd4; ds_valid = 1'b1;
    tick();
    ds_valid = 1'b0;
    chk("credit_ds_registered", 512'(last_acc), 512'(0));
    wait_accept(4, acc);
    in_valid = 1'b0;
    chk("credit_resume", 512'(acc), 512'(1));
    send_flit(1'b0, 1'b1, "credit_eop");
    chk("credit_eop_idle", 512'(dut.state_q), 512'(ST_IDLE));
    wait_ack(20, "credit_ack_after_pkt");

    // counter wrap: consumed count ahead of zero-based sent count
    do_reset();
    ds_consumed_flit = 32'hFFFF_FFFA; ds_valid = 1'b1;
    tick();
    ds_valid = 1'b0;
    chk("wrap_inflight6", 512'(dut.u_credit.in_flight), 512'(6));
    send_flit(1'b1, 1'b0, "wrap_f0");
    send_flit(1'b0, 1'b0, "wrap_f1");
    chk("wrap_sent", 512'(dut.u_credit.sent_cnt_q), 512'(2));
    chk("wrap_inflight8", 512'(dut.u_credit.in_flight), 512'(8));
    chk("wrap_credit_ok", 512'(dut.u_credit.credit_ok), 512'(0));
    push_drive(1'b0, 1'b1);
    tick();
    chk("wrap_held", 512'(last_acc), 512'(0));
    in_valid = 1'b0;

    // ACK waits for end of packet and carries the snapshot
    do_reset();
    local_consumed_flit = 32'h0000_1234; exp_ack = 32'h0000_1234;
    send_flit(1'b1, 1'b0, "ackpri_sop");
    base = ack_cnt;
    for (int i = 0; i < 20; i++) tick();
    chk("ackpri_no_ack_mid", 512'(ack_cnt - base), 512'(0));
    chk("ackpri_pending", 512'(dut.ack_pending_q), 512'(1));
    send_flit(1'b0, 1'b1, "ackpri_eop");
    wait_ack(4, "ackpri_ack");
    chk("ackpri_sent", 512'(dut.u_credit.sent_cnt_q), 512'(2));

    // ACK under backpressure holds its data while local count moves on
    do_reset();
    local_consumed_flit = 32'h0000_ABCD; exp_ack = 32'h0000_ABCD;
    out_ready = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    chk("bp_ack_valid", 512'(out_valid), 512'(1));
    held = out_data;
    local_consumed_flit = 32'h0000_5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data_stable", out_data, held);
    end
    chk("bp_in_ready", 512'(in_ready), 512'(0));
    out_ready = 1'b1;
    base = ack_cnt;
    tick();
    chk("bp_one_ack", 512'(ack_cnt - base), 512'(1));
    exp_ack = 32'h0000_5555;
    tick();
    tick();
    chk("bp_no_second_ack", 512'(out_valid), 512'(0));
    chk("bp_sent_unchanged", 512'(dut.u_credit.sent_cnt_q), 512'(0));

    // consumed-count update and a send in the same cycle
    do_reset();
    for (int i = 0; i < 7; i++) send_flit(i == 0, 1'b0, "sim_fill");
    chk("sim_inflight7", 512'(dut.u_credit.in_flight), 512'(7));
    ds_consumed_flit = 32'd5; ds_valid = 1'b1;
    push_drive(1'b0, 1'b0);
    tick();
    ds_valid = 1'b0; in_valid = 1'b0;
    chk("sim_accepted", 512'(last_acc), 512'(1));
    chk("sim_inflight3", 512'(dut.u_credit.in_flight), 512'(3));
    send_flit(1'b0, 1'b1, "sim_eop");

    // asynchronous reset in the middle of a packet
    do_reset();
    for (int i = 0; i < 3; i++) send_flit(i == 0, 1'b0, "arst_fill");
    in_data = mk_data(); in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    #1;
    chk("arst_pre_valid", 512'(out_valid), 512'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 512'(out_valid), 512'(0));
    chk("arst_state", 512'(dut.state_q), 512'(ST_IDLE));
    chk("arst_sent", 512'(dut.u_credit.sent_cnt_q), 512'(0));
    chk("arst_ds", 512'(dut.u_credit.ds_cnt_q), 512'(0));
    chk("arst_timer", 512'(dut.timer_q), 512'(0));
    chk("arst_snap", 512'(dut.snap_q), 512'(0));
    @(negedge clk);
    exp_q.delete(); in_pkt = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
    send_flit(1'b1, 1'b1, "single_flit");
    chk("single_flit_idle", 512'(dut.state_q), 512'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flow_control_scheduler.md
FLOW_CONTROL_SCHEDULER -- requirements
Module: flow_control_scheduler

Interface
REQ-001 SHALL have parameter IN_BUF_DEPTH, default 256, meaning downstream input-buffer capacity in flits (credit limit).
REQ-002 SHALL have parameter ACK_PERIOD, default 64, meaning cycles between upstream ACK requests.
REQ-003 SHALL have port clk  input  1  the single clock; all logic SHALL be on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_data/in_valid/in_sop/in_eop/in_empty  input  512/1/1/1/6  local data packet stream, flits.
REQ-006 SHALL have port in_ready  output  1  data flit accepted when in_valid & in_ready.
REQ-007 SHALL have ports out_data/out_valid/out_sop/out_eop/out_empty  output  512/1/1/1/6  merged link stream toward the peer FPGA.
REQ-008 SHALL have port out_ready  input  1  link backpressure.
REQ-009 SHALL have ports ds_consumed_flit/ds_valid  input  32/1  peer-consumed flit count from the link parser, valid 1 cycle.
REQ-010 SHALL have port local_consumed_flit  input  32  flits this FPGA has consumed from its own input buffer, reported upstream.

Function
REQ-011 SHALL keep 32-bit registers sent_cnt (data flits accepted) and ds_cnt (last ds_consumed_flit when ds_valid).
REQ-012 SHALL compute in_flight = sent_cnt - ds_cnt modulo 2^32; credit_ok = (in_flight < IN_BUF_DEPTH); correct across counter wrap.
REQ-013 SHALL use registered sent_cnt/ds_cnt for credit_ok; a ds_valid update and a flit send in one cycle SHALL both take effect next cycle.
REQ-014 SHALL run FSM states IDLE (packet boundary), DATA (mid-packet), ACK (emitting ACK flit).
REQ-015 IDLE: if ack_pending -> ACK; else pass a data flit when in_valid & in_sop & credit_ok; accepted sop without eop -> DATA; sop+eop stays IDLE.
REQ-016 DATA: pass flits while credit_ok; accepted eop -> IDLE; ACK SHALL NOT preempt mid-packet.
REQ-017 Data passthrough SHALL be combinational: out_* = in_*, out_valid = in_valid & credit_ok & state-allows, in_ready = out_ready & credit_ok & state-allows; zero latency.
REQ-018 ACK: out_valid=1, out_sop=out_eop=1, out_data = ack_pkt_t with IPv4/UDP header, udp_sport = ACK_PKT_PORT, data = snapshot; in_ready=0; -> IDLE when out_ready.
REQ-019 SHALL snapshot local_consumed_flit on the IDLE->ACK transition and hold out_data stable until accepted.
REQ-020 ACK flits SHALL NOT increment sent_cnt nor require credit (the peer parser drops them).
REQ-021 SHALL count a timer 0..ACK_PERIOD-1; at terminal count set ack_pending; ack_pending cleared when ACK flit accepted; a timeout while pending is absorbed (no queueing).
REQ-022 In IDLE, in_valid without in_sop SHALL be held off (in_ready=0) rather than forwarded.

Reset
REQ-023 On rst: sent_cnt=0, ds_cnt=0, timer=0, ack_pending=0, state=IDLE, snapshot=0; out_valid=0, in_ready=0 while rst asserted.
REQ-024 Reset mid-packet or mid-ACK SHALL abort immediately; no flit completion guaranteed.

Structure
REQ-025 ack_pkt_t, ACK_PKT_PORT, PROT_ETH, IP_V4, PROT_UDP, ACK_EMPTY SHALL come from the shared struct_s package, shared with the link parser.
REQ-026 A sub-module flow_control_credit (counters, wrap-safe in_flight, credit_ok) is natural; FSM and ACK formatting stay in the top.

Verification (IN_BUF_DEPTH=8, ACK_PERIOD=16)
REQ-027 Credit stop: 10-flit packet, out_ready=1, no ds_valid -> exactly 8 flits pass, in_ready=0 after; ds_valid with 4 -> 2 remaining flits pass, eop returns IDLE.
REQ-028 Wrap: preload sent_cnt=0xFFFFFFFE, ds_cnt=0xFFFFFFFA; send 4 flits -> sent_cnt=0x00000002, in_flight=8, credit_ok=0.
REQ-029 ACK priority: ACK timeout mid-packet -> ACK emitted only after eop, with sop=eop=1, udp_sport=ACK_PKT_PORT, data=local_consumed_flit sampled at IDLE->ACK (e.g. 0x1234).
REQ-030 Backpressure: out_ready=0 for 5 cycles during ACK -> out_data stable, one ACK accepted, sent_cnt unchanged.
REQ-031 Simultaneous: ds_valid=5 and data flit accepted same cycle with in_flight=7 -> next cycle in_flight=3.
REQ-032 Reset mid-DATA at flit 3 -> state IDLE, all counters 0, out_valid=0 asynchronously.
